// File: rtl/inlet_valve_sequencer.sv
// inlet_valve_sequencer: dispenses masked mixing-tree inlets in ascending order with dwell/settle timing.
// Optional macro INLET_FLUSH_EN adds a FLUSH phase of dwell cycles before DONE.
module inlet_valve_sequencer #(
    parameter int N_INPUTS      = 64,
    parameter int IDX_W         = 6,
    parameter int DWELL_W       = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [N_INPUTS-1:0] inlet_mask,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [N_INPUTS-1:0] valve_open,
    output logic                out_valve,
    output logic                flush_valve,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    cur_index
);
`ifdef INLET_FLUSH_EN
    typedef enum logic [2:0] {IDLE, SELECT, DISPENSE, SETTLE, FLUSH, DONE} state_t;
    localparam state_t FIN = FLUSH;
`else
    typedef enum logic [2:0] {IDLE, SELECT, DISPENSE, SETTLE, DONE} state_t;
    localparam state_t FIN = DONE;
`endif
    state_t state, state_n;
    logic [N_INPUTS-1:0] mask_q, mask_n, pick;
    logic [DWELL_W-1:0]  dwell_q, dwell_n, cnt, cnt_n, d_eff;
    logic [IDX_W-1:0]    idx_n, first;
    // SELECT is resolved combinationally on the entering edge, so it never occupies a cycle
    always_comb begin
        pick  = (state == IDLE) ? inlet_mask : mask_q;
        d_eff = (state == IDLE) ? ((dwell == '0) ? DWELL_W'(1) : dwell) : dwell_q;
        first = '0;
        for (int i = N_INPUTS - 1; i >= 0; i--)
            if (pick[i]) first = IDX_W'(i);
    end
    always_comb begin
        state_n = state;
        mask_n  = mask_q;
        dwell_n = dwell_q;
        cnt_n   = cnt;
        idx_n   = cur_index;
        if (state != IDLE && abort) begin
            state_n = IDLE;
            mask_n  = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mask_n  = inlet_mask;
                    dwell_n = d_eff;
                    state_n = |pick ? DISPENSE : FIN;
                    idx_n   = |pick ? first : cur_index;
                    cnt_n   = d_eff - 1'b1;
                end
                DISPENSE: if (cnt == '0) begin
                    mask_n[cur_index] = 1'b0;
                    state_n = SETTLE;
                    cnt_n   = DWELL_W'(SETTLE_CYCLES - 1);
                end else cnt_n = cnt - 1'b1;
                SETTLE: if (cnt == '0) begin
                    state_n = |pick ? DISPENSE : FIN;
                    idx_n   = |pick ? first : cur_index;
                    cnt_n   = d_eff - 1'b1;
                end else cnt_n = cnt - 1'b1;
`ifdef INLET_FLUSH_EN
                FLUSH: begin
                    state_n = (cnt == '0) ? DONE : FLUSH;
                    cnt_n   = cnt - 1'b1;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mask_q     <= '0;
            dwell_q    <= '0;
            cnt        <= '0;
            valve_open <= '0;
            out_valve  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_index  <= '0;
        end else begin
            state      <= state_n;
            mask_q     <= mask_n;
            dwell_q    <= dwell_n;
            cnt        <= cnt_n;
            valve_open <= (state_n == DISPENSE) ? (N_INPUTS'(1) << idx_n) : '0;
            out_valve  <= (state_n == DISPENSE) || (state_n == SETTLE) || (state_n == FIN && FIN != DONE);
            busy       <= state_n != IDLE;
            done       <= state_n == DONE;
            cur_index  <= idx_n;
        end
    end
`ifdef INLET_FLUSH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flush_valve <= 1'b0;
        else flush_valve <= state_n == FLUSH;
    end
`else
    assign flush_valve = 1'b0;
`endif
endmodule

// File: tb/tb_inlet_valve_sequencer.sv
// tb_inlet_valve_sequencer: randomized and directed checks against a per-cycle expected-trace model.
module tb_inlet_valve_sequencer;
    typedef struct packed {
        logic [63:0] v;
        logic        o, f, b, d;
        logic [5:0]  i;
    } ent_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [63:0] inlet_mask = '0, valve_open;
    logic [15:0] dwell = '0;
    logic        out_valve, flush_valve, busy, done;
    logic [5:0]  cur_index;
    int checks = 0, failures = 0;
    logic [5:0] last_idx = '0;

    inlet_valve_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .inlet_mask(inlet_mask), .dwell(dwell),
        .valve_open(valve_open), .out_valve(out_valve), .flush_valve(flush_valve),
        .busy(busy), .done(done), .cur_index(cur_index)
    );

    always #5 clk = ~clk;

    function automatic ent_t observed();
        return {valve_open, out_valve, flush_valve, busy, done, cur_index};
    endfunction

    task automatic check(input string tag, input ent_t obs, input ent_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected behaviour: each set bit ascending gets dwell open cycles then 4 closed settle cycles,
    // optional flush for dwell cycles, then a single done cycle; abort drops straight to idle.
    task automatic run(input logic [63:0] m, input logic [15:0] d, input int hold_start,
                       input int abort_at, input string tag);
        ent_t q[$];
        ent_t exp;
        int de;
        logic [5:0] cur;
        cur = last_idx;
        de = (d == 0) ? 1 : int'(d);
        for (int i = 0; i < 64; i++) if (m[i]) begin
            cur = 6'(i);
            repeat (de) q.push_back({64'd1 << i, 1'b1, 1'b0, 1'b1, 1'b0, cur});
            repeat (4) q.push_back({64'd0, 1'b1, 1'b0, 1'b1, 1'b0, cur});
        end
`ifdef INLET_FLUSH_EN
        repeat (de) q.push_back({64'd0, 1'b1, 1'b1, 1'b1, 1'b0, cur});
`endif
        q.push_back({64'd0, 1'b0, 1'b0, 1'b1, 1'b1, cur});
        if (abort_at >= 0) last_idx = q[abort_at].i;
        else last_idx = cur;
        start = 1'b1;
        inlet_mask = m;
        dwell = d;
        for (int c = 0; c < q.size() + 2; c++) begin
            @(posedge clk);
            #1;
            if (abort_at >= 0 && c > abort_at) exp = {64'd0, 1'b0, 1'b0, 1'b0, 1'b0, last_idx};
            else if (c < q.size()) exp = q[c];
            else exp = {64'd0, 1'b0, 1'b0, 1'b0, 1'b0, last_idx};
            check($sformatf("%s_c%0d", tag, c), observed(), exp);
            start = (c < hold_start);
            inlet_mask = {$urandom, $urandom};
            dwell = 16'($urandom);
            abort = (c == abort_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #1;
        check("reset_async", observed(), '0);
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_idle", observed(), '0);
        run(64'h5, 16'd3, 3, -1, "mask5_d3");
        run(64'h0, 16'd7, 0, -1, "mask0");
        run('1, 16'd0, 40, -1, "all_d0");
        run(64'h3, 16'd3, 5, 8, "abort2nd");
        for (int r = 0; r < 6; r++)
            run({$urandom & $urandom & $urandom, $urandom & $urandom & $urandom},
                16'($urandom_range(0, 5)), int'($urandom_range(0, 6)), -1, $sformatf("rnd%0d", r));
        run(64'h8000_0000_0000_0001, 16'd2, 0, -1, "edges");
        start = 1'b1;
        inlet_mask = 64'h5;
        dwell = 16'd3;
        @(posedge clk);
        #1;
        check("pre_rst_dispense", observed(), {64'd1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0});
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_dispense", observed(), '0);
        start = 1'b0;
        #2;
        rst = 1'b0;
        last_idx = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_resume", observed(), '0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
